cmd_uart_sender: RTL
====================

Name: cmd_uart_sender

Overview:
- Downstream executor for the link-bring-up sequencer.
- Accepts a 3-bit command index with a `start` strobe and looks up a fixed ASCII command string in an internal ROM.
- Transmits the string LSB-first over an 8N1 UART TX line to the radio module.
- Reports completion on `ready_command`, which the sequencer uses as its handshake.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- MAX_LEN, 16, maximum string length in bytes; sizes the byte counter (5 bits).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- command  in  3  command index, sampled on the start edge.
- start  in  1  request; a rising edge starts a transfer.
- ready_command  out  1  1 = idle/done, 0 = transfer in progress.
- tx  out  1  UART serial output; idle high.
- cmd_done  out  1  one-cycle pulse when a valid command's last stop bit completes.
- cmd_err  out  1  one-cycle pulse when an undefined command index is requested.

Behaviour:
- Reset (asynchronous, rst=0), all outputs and registers forced immediately:
  - ready_command=1, tx=1, cmd_done=0, cmd_err=0.
  - state=IDLE, start_d=0, bit counter=0, byte index=0.
  - A reset mid-frame truncates the frame: tx goes high without waiting for a clock.
- Edge detect:
  - start_d registers start every cycle in every state.
  - edge = start & ~start_d.
  - Edges outside IDLE are ignored and not queued.
  - start held high produces no retrigger; a low of at least one cycle followed by high does.
- ROM contents (bytes sent in order; CR=0x0D, LF=0x0A):
  - cmd 0: "AT" CR LF, 4 bytes.
  - cmd 1: "ATE0" CR LF, 6 bytes.
  - cmd 2: "AT+CWMODE=1" CR LF, 13 bytes.
  - cmd 3: "AT+CIPMUX=0" CR LF, 13 bytes.
  - cmd 4-7: length 0 (undefined).
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, ERR.
- IDLE:
  - On edge with length>0: latch command and length, byte index=0, load ROM byte into shift register, ready_command<=0, go to START_BIT.
  - On edge with length=0: ready_command<=0, go to ERR.
- ERR: lasts one cycle; cmd_err=1 for that cycle, ready_command<=1, return to IDLE. tx stays 1 throughout.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then DATA_BITS.
- DATA_BITS:
  - tx = shift register bit 0, 8 bits, each held for CLKS_PER_BIT cycles.
  - Shift right after each bit.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
  - If byte index < length-1: increment index, load the next ROM byte, go to START_BIT. Back-to-back frames, no idle gap.
  - Else: cmd_done=1 for one cycle, ready_command<=1, go to IDLE.
- Timing (all outputs registered):
  - tx falls in the same cycle ready_command falls: the first cycle after the clock edge that sampled the start edge.
  - ready_command stays low for exactly length*10*CLKS_PER_BIT cycles.
  - cmd_done is asserted in the cycle ready_command returns high.
- Sampling: command changes while busy have no effect; the latched index is used for the whole transfer.
- Counters:
  - Bit-time counter is 16-bit, counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index is 0..7; byte index is 0..MAX_LEN-1.
  - No counter exceeds its range for any legal command.
- Sequencer compatibility: ready_command is guaranteed low for at least one cycle per accepted request, so a wait-for-low-then-high handshake always completes.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset, then command=0 with a start 0→1 edge:
  - ready_command low for 160 cycles.
  - tx frames decode to 0x41 0x54 0x0D 0x0A.
  - cmd_done pulses once; cmd_err stays 0.
- Sequence of cmds 0,1,2,3, each with start dropped for 1 cycle then raised after ready returns high:
  - Decoded bytes match the ROM strings exactly.
  - ready low durations are 160/240/520/520 cycles.
- command=5 with a start edge:
  - ready_command low for exactly 1 cycle.
  - cmd_err pulses 1 cycle; tx never leaves 1; cmd_done stays 0.
- During a cmd 2 transfer, toggle start and change command to 1:
  - No effect; full 13-byte cmd 2 string is sent.
  - No second transfer afterwards.
- start held high continuously after cmd 0 completes: no retransmission for 1000 cycles; ready stays 1.
- Assert rst=0 mid-data-bit of byte 2:
  - tx=1 and ready_command=1 immediately, before the next clk edge.
  - After release, a new cmd 0 request transmits correctly.
  - Repeat with CLKS_PER_BIT=868: bit period measured as 868 cycles.

Source files
------------

// File: rtl/cmd_uart_sender.sv
// cmd_uart_sender: looks up a fixed ASCII command string by index and sends it
// over an 8N1 UART line, reporting completion on ready_command.
module cmd_uart_sender #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] command,
  input  logic       start,
  output logic       ready_command,
  output logic       tx,
  output logic       cmd_done,
  output logic       cmd_err
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT, ERR} state_t;
  state_t state;
  logic start_d;
  logic [2:0] cmd_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] idx;
  logic [7:0] sh;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic start_edge;
  logic bit_end;
  assign start_edge = start & ~start_d;
  assign bit_end = cnt == BIT_END;
  // Strings are left-aligned in a 16-byte field so byte i is always a legal slice.
  function automatic logic [7:0] rom_byte(input logic [2:0] c, input logic [3:0] i);
    logic [127:0] s;
    case (c)
      3'd0: s = {"AT", 8'h0D, 8'h0A, 96'h0};
      3'd1: s = {"ATE0", 8'h0D, 8'h0A, 80'h0};
      3'd2: s = {"AT+CWMODE=1", 8'h0D, 8'h0A, 24'h0};
      3'd3: s = {"AT+CIPMUX=0", 8'h0D, 8'h0A, 24'h0};
      default: s = '0;
    endcase
    return s[8*(15-i) +: 8];
  endfunction
  function automatic logic [IW-1:0] rom_len(input logic [2:0] c);
    case (c)
      3'd0: return IW'(4);
      3'd1: return IW'(6);
      3'd2, 3'd3: return IW'(13);
      default: return '0;
    endcase
  endfunction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      start_d <= 1'b0;
      cmd_q <= '0;
      len_q <= '0;
      idx <= '0;
      sh <= '0;
      cnt <= '0;
      bit_idx <= '0;
      ready_command <= 1'b1;
      tx <= 1'b1;
      cmd_done <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      start_d <= start;
      cmd_done <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          ready_command <= 1'b0;
          if (rom_len(command) != '0) begin
            cmd_q <= command;
            len_q <= rom_len(command);
            idx <= '0;
            sh <= rom_byte(command, 4'd0);
            cnt <= '0;
            tx <= 1'b0;
            state <= START_BIT;
          end else state <= ERR;
        end
        ERR: begin
          cmd_err <= 1'b1;
          ready_command <= 1'b1;
          state <= IDLE;
        end
        START_BIT: if (bit_end) begin
          cnt <= '0;
          tx <= sh[0];
          sh <= sh >> 1;
          bit_idx <= '0;
          state <= DATA_BITS;
        end else cnt <= cnt + 16'd1;
        DATA_BITS: if (bit_end) begin
          cnt <= '0;
          if (bit_idx == 3'd7) begin
            tx <= 1'b1;
            state <= STOP_BIT;
          end else begin
            tx <= sh[0];
            sh <= sh >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else cnt <= cnt + 16'd1;
        STOP_BIT: if (bit_end) begin
          cnt <= '0;
          if (idx + 1'b1 != len_q) begin
            idx <= idx + 1'b1;
            sh <= rom_byte(cmd_q, 4'(idx + 1'b1));
            tx <= 1'b0;
            state <= START_BIT;
          end else begin
            cmd_done <= 1'b1;
            ready_command <= 1'b1;
            state <= IDLE;
          end
        end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
